// File: rtl/sw_pkg.sv
// Shared types and constants for the Smith-Waterman tile scheduler.
package sw_pkg;

    localparam int TILE   = 16;
    localparam int CELL_W = 8;
    localparam int BASE_W = 2;
    localparam int ROW_W  = TILE * CELL_W;
    localparam int SEG_W  = TILE * BASE_W;
    localparam int IDX_W  = $clog2(TILE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    function automatic int unsigned tile_idx(
        input int unsigned r,
        input int unsigned c,
        input int unsigned grid
    );
        return r * grid + c;
    endfunction

endpackage

// File: rtl/sw_tile_scheduler_if.sv
// Solver-facing bundle: tile issue from the scheduler, results back from the solver.
interface sw_tile_scheduler_if
    import sw_pkg::*;
#(
    parameter int GRID = 4,
    localparam int TN_W = $clog2(GRID * GRID)
);

    logic [TN_W-1:0]   tileNum;
    logic [SEG_W-1:0]  S1;
    logic [SEG_W-1:0]  S2;
    logic [ROW_W-1:0]  firstRow;
    logic [ROW_W-1:0]  firstCol;
    logic [CELL_W-1:0] diagonalCell;

    logic [ROW_W-1:0]  solLastRow;
    logic [ROW_W-1:0]  solLastCol;
    logic [CELL_W-1:0] solMaxValue;
    logic [IDX_W-1:0]  solMaxIdx;
    logic [TN_W-1:0]   solTileNumOut;
    logic              solValid;

    modport master (
        output tileNum, S1, S2, firstRow, firstCol, diagonalCell,
        input  solLastRow, solLastCol, solMaxValue, solMaxIdx,
        input  solTileNumOut, solValid
    );

    modport slave (
        input  tileNum, S1, S2, firstRow, firstCol, diagonalCell,
        output solLastRow, solLastCol, solMaxValue, solMaxIdx,
        output solTileNumOut, solValid
    );

endinterface

// File: rtl/sw_max_tracker.sv
// Running global maximum over tile results; ties keep the earlier tile.
module sw_max_tracker
    import sw_pkg::*;
#(
    parameter int TN_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              update,
    input  logic [CELL_W-1:0] value,
    input  logic [TN_W-1:0]   tile,
    input  logic [IDX_W-1:0]  idx,
    output logic [CELL_W-1:0] best_score,
    output logic [TN_W-1:0]   best_tile,
    output logic [IDX_W-1:0]  best_idx
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            best_score <= '0;
            best_tile  <= '0;
            best_idx   <= '0;
        end else if (clear) begin
            best_score <= '0;
            best_tile  <= '0;
            best_idx   <= '0;
        end else if (update && (value > best_score)) begin
            best_score <= value;
            best_tile  <= tile;
            best_idx   <= idx;
        end
    end

endmodule

// File: rtl/sw_tile_scheduler.sv
// Walks a GRID x GRID tile grid row-major, feeding each tile its
// boundaries from previously captured solver results.
module sw_tile_scheduler
    import sw_pkg::*;
#(
    parameter int GRID = 4,
    localparam int TN_W  = $clog2(GRID * GRID),
    localparam int RC_W  = $clog2(GRID),
    localparam int SEQ_W = BASE_W * TILE * GRID
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SEQ_W-1:0]   seqA,
    input  logic [SEQ_W-1:0]   seqB,
    sw_tile_scheduler_if.master sol,
    output logic               busy,
    output logic               done,
    output logic [CELL_W-1:0]  bestScore,
    output logic [TN_W-1:0]    bestTile,
    output logic [IDX_W-1:0]   bestIdx
);

    state_t state, nxt;

    logic [RC_W-1:0]   r, c;
    logic [SEQ_W-1:0]  seq_a, seq_b;
    logic [ROW_W-1:0]  row_buf [GRID];
    logic [ROW_W-1:0]  col_reg;
    logic [CELL_W-1:0] corner;
    logic              capture, last, load;

    assign load    = (state == S_LOAD);
    assign last    = (r == RC_W'(GRID - 1)) && (c == RC_W'(GRID - 1));
    assign capture = (state == S_WAIT) && sol.solValid
                   && (sol.solTileNumOut == sol.tileNum);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt  = state;
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            S_IDLE:  if (start) nxt = S_LOAD;
            S_LOAD: begin
                busy = 1'b1;
                nxt  = S_ISSUE;
            end
            S_ISSUE: begin
                busy = 1'b1;
                nxt  = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (capture) nxt = last ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done = 1'b1;
                nxt  = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // The corner for the next tile is the last cell of the row being replaced.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_a   <= '0;
            seq_b   <= '0;
            r       <= '0;
            c       <= '0;
            col_reg <= '0;
            corner  <= '0;
            for (int i = 0; i < GRID; i++) row_buf[i] <= '0;
        end else if (load) begin
            seq_a   <= seqA;
            seq_b   <= seqB;
            r       <= '0;
            c       <= '0;
            col_reg <= '0;
            corner  <= '0;
            for (int i = 0; i < GRID; i++) row_buf[i] <= '0;
        end else if (capture) begin
            corner     <= row_buf[c][ROW_W-1 -: CELL_W];
            row_buf[c] <= sol.solLastRow;
            col_reg    <= sol.solLastCol;
            if (!last) begin
                if (c == RC_W'(GRID - 1)) begin
                    c <= '0;
                    r <= r + 1'b1;
                end else begin
                    c <= c + 1'b1;
                end
            end
        end
    end

    assign sol.tileNum      = TN_W'(tile_idx(r, c, GRID));
    assign sol.S1           = seq_a[SEG_W * c +: SEG_W];
    assign sol.S2           = seq_b[SEG_W * r +: SEG_W];
    assign sol.firstRow     = (r == '0) ? '0 : row_buf[c];
    assign sol.firstCol     = (c == '0) ? '0 : col_reg;
    assign sol.diagonalCell = ((r == '0) || (c == '0)) ? '0 : corner;

    sw_max_tracker #(
        .TN_W(TN_W)
    ) u_max (
        .clk        (clk),
        .reset      (reset),
        .clear      (load),
        .update     (capture),
        .value      (sol.solMaxValue),
        .tile       (sol.tileNum),
        .idx        (sol.solMaxIdx),
        .best_score (bestScore),
        .best_tile  (bestTile),
        .best_idx   (bestIdx)
    );

endmodule
